// File: rtl/mips_mem_responder.sv
// Memory-side responder for the mips core: instruction/data RAMs, a preload
// port, and a sequencer that holds the core in reset until loading is done.
module mips_mem_responder #(
  parameter int          IM_WORDS   = 1024,
  parameter int          DM_WORDS   = 1024,
  parameter logic [31:0] DM_LIMIT   = 32'h000000ff,
  parameter int          SETTLE_CYC = 2
) (
  input  logic        CLK,
  input  logic        Z_R,
  input  logic [31:0] IM_ADDR,
  output logic [31:0] IM_DATA,
  input  logic        DM_WE,
  input  logic [31:0] DM_ADDR,
  input  logic [31:0] DM_WR_DATA,
  output logic [31:0] DM_RD_DATA,
  input  logic        LD_EN,
  input  logic        LD_SEL,
  input  logic [9:0]  LD_ADDR,
  input  logic [31:0] LD_DATA,
  input  logic        LD_DONE,
  output logic        CORE_Z_R,
  output logic        DM_ERR,
  output logic [15:0] DM_WR_CNT
);

  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN
  } state_e;

  state_e      state_q;
  logic [7:0]  settle_q;
  logic [31:0] im_data_q;
  logic [31:0] dm_rd_q;
  logic        core_z_r_q;
  logic        dm_err_q;
  logic [15:0] dm_cnt_q;

  logic [31:0] imem [IM_WORDS];
  logic [31:0] dmem [DM_WORDS];

  logic [IAW-1:0] im_idx;
  logic [DAW-1:0] dm_idx;
  logic [31:0]    ld_word;
  logic           im_hit;
  logic           dm_oor;
  logic           im_ld_we;
  logic           dm_ld_we;
  logic           dm_st_we;
  logic           unused_ok;

  assign im_idx  = IM_ADDR[IAW+1:2];
  assign dm_idx  = DM_ADDR[DAW+1:2];
  assign ld_word = {22'b0, LD_ADDR};

  // Fetches beyond the instruction RAM return a nop rather than aliasing.
  assign im_hit = IM_ADDR[31:2] < 30'(IM_WORDS);
  assign dm_oor = DM_ADDR > DM_LIMIT;

  assign im_ld_we = (state_q == LOAD) && LD_EN && !LD_SEL
                    && (ld_word < 32'(IM_WORDS));
  assign dm_ld_we = (state_q == LOAD) && LD_EN && LD_SEL
                    && (ld_word < 32'(DM_WORDS));
  assign dm_st_we = (state_q == RUN) && DM_WE && !dm_oor;

  assign unused_ok = ^{IM_ADDR[1:0], DM_ADDR[1:0], ld_word[31:IAW]};

  always_ff @(posedge CLK) begin
    if (im_ld_we) imem[ld_word[IAW-1:0]] <= LD_DATA;
    if (dm_ld_we) dmem[ld_word[DAW-1:0]] <= LD_DATA;
    else if (dm_st_we) dmem[dm_idx] <= DM_WR_DATA;
  end

  always_ff @(posedge CLK or negedge Z_R) begin
    if (!Z_R) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      im_data_q  <= '0;
      dm_rd_q    <= '0;
      core_z_r_q <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= LOAD;
        end
        LOAD: begin
          im_data_q <= '0;
          dm_rd_q   <= '0;
          if (LD_DONE) begin
            state_q  <= SETTLE;
            settle_q <= '0;
          end
        end
        SETTLE: begin
          if (settle_q == 8'(SETTLE_CYC)) begin
            state_q    <= RUN;
            core_z_r_q <= 1'b1;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        RUN: begin
          im_data_q <= im_hit ? imem[im_idx] : 32'h0;
          if (DM_WE) begin
            if (dm_oor) dm_err_q <= 1'b1;
            else if (dm_cnt_q != 16'hffff)
              dm_cnt_q <= dm_cnt_q + 16'd1;
          end else begin
            dm_rd_q <= dm_oor ? 32'hffffffff : dmem[dm_idx];
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign IM_DATA    = im_data_q;
  assign DM_RD_DATA = dm_rd_q;
  assign CORE_Z_R   = core_z_r_q;
  assign DM_ERR     = dm_err_q;
  assign DM_WR_CNT  = dm_cnt_q;

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Synthesizable memory-side responder for the mips core's instruction and data memory ports, sharing one clock with the core. Holds word-addressed instruction and data RAMs and a load port used to preload program and data images. Runs a small sequencer that keeps the core in reset until loading completes. Answers core fetches, loads and stores with fixed one-cycle latency, returns all-ones for out-of-range data reads, and keeps sticky error and store-count status.

Parameters:
IM_WORDS, 1024, instruction RAM depth in 32-bit words (index = IM_ADDR[11:2])
DM_WORDS, 1024, data RAM depth in 32-bit words (index = DM_ADDR[11:2])
DM_LIMIT, 32'h000000ff, highest valid DM byte address; above it is out of range
SETTLE_CYC, 2, cycles between LD_DONE and core reset release

Ports:
CLK  in  1  single clock, rising edge
Z_R  in  1  asynchronous active-low reset
IM_ADDR  in  32  core fetch byte address
IM_DATA  out  32  fetched instruction
DM_WE  in  1  core store strobe
DM_ADDR  in  32  core data byte address
DM_WR_DATA  in  32  store data
DM_RD_DATA  out  32  load data
LD_EN  in  1  preload write strobe
LD_SEL  in  1  0 = instruction RAM, 1 = data RAM
LD_ADDR  in  10  preload word index
LD_DATA  in  32  preload word
LD_DONE  in  1  preload complete pulse
CORE_Z_R  out  1  active-low reset to the core
DM_ERR  out  1  sticky out-of-range store flag
DM_WR_CNT  out  16  committed store count, saturating

Behaviour:
- Reset (Z_R low, async): state IDLE. IM_DATA=0, DM_RD_DATA=0, CORE_Z_R=0, DM_ERR=0, DM_WR_CNT=0, settle counter=0. RAM contents are not cleared.
- FSM transitions:
  - IDLE -> LOAD on the first rising edge with Z_R high.
  - LOAD -> SETTLE on the edge where LD_DONE=1.
  - SETTLE counts SETTLE_CYC edges, then -> RUN.
  - RUN stays in RUN until Z_R goes low.
- CORE_Z_R is registered. It goes 1 on the edge entering RUN and is 0 in every other state. It drops asynchronously with Z_R.
- LOAD state:
  - LD_EN=1 writes LD_DATA to the RAM selected by LD_SEL at LD_ADDR on that edge.
  - LD_EN together with LD_DONE on the same edge: the write is performed and the state advances.
  - LD_ADDR at or beyond the depth: write dropped, no flag.
  - Core ports are ignored; IM_DATA and DM_RD_DATA hold 0.
- LD_EN outside LOAD is ignored.
- RUN state, fetch: IM_DATA <= imem[IM_ADDR[11:2]] each edge (1-cycle latency). Index >= IM_WORDS returns 32'h00000000 (nop). IM_ADDR[1:0] is ignored.
- RUN state, store (DM_WE=1 at the edge):
  - DM_ADDR <= DM_LIMIT: dmem[DM_ADDR[11:2]] <= DM_WR_DATA and DM_WR_CNT increments, saturating at 16'hffff.
  - DM_ADDR > DM_LIMIT (full 32-bit unsigned compare): store dropped, DM_ERR <= 1, count unchanged.
  - DM_RD_DATA holds its previous value.
- RUN state, load (DM_WE=0 at the edge): DM_RD_DATA <= (DM_ADDR > DM_LIMIT) ? 32'hffffffff : dmem[DM_ADDR[11:2]]. 1-cycle latency.
- Read-after-write: a store at edge N followed by a load of the same word at edge N+1 returns the new data. There is no same-edge bypass.
- DM_ERR clears only on reset.
- Reset mid-RUN: the core is held in reset immediately and the FSM restarts at IDLE -> LOAD. Previously loaded RAM contents survive, so LD_DONE with no LD_EN writes reruns the same image.

Test Plan:
- Reset sequence: hold Z_R=0 5 cycles, release, load imem[0..3]=0x20080005,0x20090007,0x01095020,0xac0a0004, pulse LD_DONE -> CORE_Z_R rises exactly 3 edges after the LD_DONE edge; all outputs 0 before that.
- Fetch: in RUN, IM_ADDR=0x8 -> IM_DATA=0x01095020 one edge later; IM_ADDR=0x1000 -> 0x00000000.
- Store/load: DM_WE=1, DM_ADDR=0x4, DM_WR_DATA=0x0000000c, then a load of 0x4 on the next edge -> DM_RD_DATA=0x0000000c; DM_WR_CNT=1; DM_RD_DATA unchanged on the store edge.
- Out of range: store to 0x100 -> memory unchanged, DM_ERR=1, count unchanged; load from 0x100 -> 0xffffffff; load from 0xfc -> dmem[63].
- Boundaries: 65536 stores -> DM_WR_CNT stays 0xffff; LD_EN with LD_DONE on the same edge -> the word is written and the FSM enters SETTLE.
- Async reset mid-RUN: drop Z_R between edges -> CORE_Z_R=0 and outputs 0 without a clock edge; reload with LD_DONE only -> the prior program executes identically.
